// File: rtl/lsu_byte_engine.sv
// lsu_byte_engine: splits LSB loads/stores into little-endian byte transactions and returns extended load data.
`ifndef LSU_OPS_DEFINED
`define LSU_OPS_DEFINED
`define OP_ENUM_TYPE [3:0]
`define LB 4'd0
`define LH 4'd1
`define LW 4'd2
`define LBU 4'd3
`define LHU 4'd4
`define SB 4'd5
`define SH 4'd6
`define SW 4'd7
`define READ_SIT 1'b0
`define WRITE_SIT 1'b1
`endif

module lsu_byte_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    enable_from_lsb,
    input  logic                    read_write_flag_from_lsb,
    input  logic `OP_ENUM_TYPE      op_enum_from_lsb,
    input  logic [ADDR_WIDTH-1:0]   object_address_from_lsb,
    input  logic [DATA_WIDTH-1:0]   data_from_lsb,
    output logic                    busy_to_lsb,
    output logic                    end_to_lsb,
    output logic [DATA_WIDTH-1:0]   data_to_lsb,
    output logic                    enable_to_cdb,
    output logic [DATA_WIDTH-1:0]   result_to_cdb,
    input  logic                    roll_back_flag_from_rob,
    output logic                    mem_req,
    output logic                    mem_wr,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [7:0]              mem_wdata,
    input  logic                    mem_ack,
    input  logic [7:0]              mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t st;
    logic `OP_ENUM_TYPE op;
    logic [ADDR_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] sdata, asm_q, asm_n, ext;
    logic rw, squash, load, kill, issue_load;
    logic [1:0] k, kn, last, last_in;

    assign busy_to_lsb = (st != IDLE) | enable_from_lsb;
    assign load = rw == `READ_SIT;
    assign issue_load = read_write_flag_from_lsb == `READ_SIT;
    assign kill = squash | (roll_back_flag_from_rob & load);
    assign kn = k + 2'd1;
    assign last_in = (op_enum_from_lsb == `LB || op_enum_from_lsb == `LBU || op_enum_from_lsb == `SB) ? 2'd0 :
                     (op_enum_from_lsb == `LH || op_enum_from_lsb == `LHU || op_enum_from_lsb == `SH) ? 2'd1 : 2'd3;

    always_comb begin
        asm_n = asm_q;
        asm_n[{k, 3'b000} +: 8] = mem_rdata;
        ext = (op == `LB)  ? {{(DATA_WIDTH-8){asm_n[7]}}, asm_n[7:0]} :
              (op == `LH)  ? {{(DATA_WIDTH-16){asm_n[15]}}, asm_n[15:0]} :
              (op == `LBU) ? {{(DATA_WIDTH-8){1'b0}}, asm_n[7:0]} :
              (op == `LHU) ? {{(DATA_WIDTH-16){1'b0}}, asm_n[15:0]} : asm_n;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            st <= IDLE;
            op <= '0;
            base <= '0;
            sdata <= '0;
            asm_q <= '0;
            rw <= 1'b0;
            squash <= 1'b0;
            k <= '0;
            last <= '0;
            mem_req <= 1'b0;
            mem_wr <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            end_to_lsb <= 1'b0;
            enable_to_cdb <= 1'b0;
            data_to_lsb <= '0;
            result_to_cdb <= '0;
        end else if (rdy_in) begin
            end_to_lsb <= 1'b0;
            enable_to_cdb <= 1'b0;
            case (st)
                IDLE: if (enable_from_lsb && !(roll_back_flag_from_rob && issue_load)) begin
                    op <= op_enum_from_lsb;
                    base <= object_address_from_lsb;
                    sdata <= data_from_lsb;
                    rw <= read_write_flag_from_lsb;
                    last <= last_in;
                    k <= '0;
                    asm_q <= '0;
                    squash <= 1'b0;
                    mem_req <= 1'b1;
                    mem_wr <= read_write_flag_from_lsb == `WRITE_SIT;
                    mem_addr <= object_address_from_lsb;
                    mem_wdata <= data_from_lsb[7:0];
                    st <= REQ;
                end
                REQ: begin
                    if (roll_back_flag_from_rob && load) squash <= 1'b1;
                    if (mem_ack) begin
                        if (load) asm_q <= asm_n;
                        // a squashed load still waits out its pending byte, then drops silently
                        if (kill) begin
                            mem_req <= 1'b0;
                            squash <= 1'b0;
                            st <= IDLE;
                        end else if (k == last) begin
                            mem_req <= 1'b0;
                            end_to_lsb <= 1'b1;
                            st <= DONE;
                            if (load) begin
                                enable_to_cdb <= 1'b1;
                                data_to_lsb <= ext;
                                result_to_cdb <= ext;
                            end
                        end else begin
                            k <= kn;
                            mem_addr <= base + ADDR_WIDTH'(kn);
                            mem_wdata <= sdata[{kn, 3'b000} +: 8];
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule
